// File: rtl/lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx : panel-side receiver for the 4-wire LCD SPI link (scl/sda/cs/rs).
//
// Oversamples the serial lines in the clk domain, assembles MSB-first bytes and
// decodes the ST7735-style commands CASET (0x2A), RASET (0x2B) and RAMWR (0x2C)
// into addressed RGB565 pixel writes. Useful as a loopback display model or as
// an on-chip frame-capture port.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   scl_lcd    in   SPI clock (async to clk)
//   sda_lcd    in   SPI data, sampled on scl rising edge
//   cs_lcd     in   chip select, active-low
//   rs_lcd     in   0 = command byte, 1 = data byte (taken with bit 0)
//   rst_lcd    in   panel reset, active-low, soft reset of the decoder
//   cmd_valid  out  one-cycle strobe per command byte
//   cmd_byte   out  last command value
//   pix_valid  out  one-cycle strobe per completed pixel
//   pix_x/y    out  pixel column / row
//   pix_data   out  RGB565 pixel, first byte in [15:8]
//   frame_done out  strobe with the pixel written at (xe, ye)
//   frag_err   out  strobe when cs rises with a partial byte shifted
//   byte_cnt   out  (LCD_SPI_RX_BYTECNT_EN only) saturating count of bytes
//   cmd_cnt    out  (LCD_SPI_RX_BYTECNT_EN only) saturating count of commands
//
// Optional feature macro: LCD_SPI_RX_BYTECNT_EN adds byte_cnt / cmd_cnt.
// -----------------------------------------------------------------------------
module lcd_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8,
    parameter int DEF_XE      = 127,
    parameter int DEF_YE      = 159
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_lcd,
    input  logic              sda_lcd,
    input  logic              cs_lcd,
    input  logic              rs_lcd,
    input  logic              rst_lcd,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_x,
    output logic [ADDR_W-1:0] pix_y,
    output logic [15:0]       pix_data,
    output logic              frame_done,
`ifdef LCD_SPI_RX_BYTECNT_EN
    output logic [15:0]       byte_cnt,
    output logic [15:0]       cmd_cnt,
`endif
    output logic              frag_err
);

    typedef enum logic [2:0] {IDLE, CASET_P, RASET_P, RAMWR_HI, RAMWR_LO} state_t;

    localparam logic [ADDR_W-1:0] DEF_XE_W = ADDR_W'(DEF_XE);
    localparam logic [ADDR_W-1:0] DEF_YE_W = ADDR_W'(DEF_YE);
    localparam logic [ADDR_W-1:0] ONE_W    = ADDR_W'(1);
    // Sync vector layout {rst_lcd, rs, cs, sda, scl}; idle values keep the
    // panel out of reset and deselected.
    localparam logic [4:0]        SYNC_INIT = 5'b10100;

    // ---------------- front end: synchronizers + scl edge detect -------------
    logic [4:0] sync_reg [SYNC_STAGES];
    logic       scl_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_INIT;
        end else begin
            sync_reg[0] <= {rst_lcd, rs_lcd, cs_lcd, sda_lcd, scl_lcd};
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
    end

    logic scl_s, sda_s, cs_s, rs_s, soft_rst, scl_rise;
    assign scl_s    = sync_reg[SYNC_STAGES-1][0];
    assign sda_s    = sync_reg[SYNC_STAGES-1][1];
    assign cs_s     = sync_reg[SYNC_STAGES-1][2];
    assign rs_s     = sync_reg[SYNC_STAGES-1][3];
    assign soft_rst = ~sync_reg[SYNC_STAGES-1][4];
    assign scl_rise = scl_s & ~scl_prev_reg;

    // ---------------- shifter ------------------------------------------------
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       frag_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_reg <= 1'b0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            frag_err_reg <= 1'b0;
        end else begin
            scl_prev_reg <= scl_s;
            frag_err_reg <= 1'b0;
            if (soft_rst) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
            end else if (cs_s) begin
                // Counter is cleared here, so a partial byte flags only once.
                if (bit_cnt_reg != 3'd0) frag_err_reg <= 1'b1;
                bit_cnt_reg <= '0;
            end else if (scl_rise) begin
                shift_reg   <= {shift_reg[5:0], sda_s};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;   // wraps to 0 after 8th bit
            end
        end
    end

    // The completed byte is handed to the decoder combinationally so that its
    // registered strobes appear one clk after the 8th rise is detected.
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       rx_rs;
    assign byte_done = scl_rise & ~cs_s & ~soft_rst & (bit_cnt_reg == 3'd7);
    assign rx_byte   = {shift_reg, sda_s};
    assign rx_rs     = rs_s;

    // ---------------- decoder ------------------------------------------------
    state_t            state_reg, state_next;
    logic [1:0]        pidx_reg, pidx_next;
    logic [23:0]       pbuf_reg, pbuf_next;
    logic [7:0]        hi_reg, hi_next;
    logic [ADDR_W-1:0] x_reg, x_next, y_reg, y_next;
    logic [ADDR_W-1:0] xs_reg, xs_next, xe_reg, xe_next;
    logic [ADDR_W-1:0] ys_reg, ys_next, ye_reg, ye_next;
    logic              cmd_valid_reg, cmd_valid_next;
    logic [7:0]        cmd_byte_reg, cmd_byte_next;
    logic              pix_valid_reg, pix_valid_next;
    logic [ADDR_W-1:0] pix_x_reg, pix_x_next, pix_y_reg, pix_y_next;
    logic [15:0]       pix_data_reg, pix_data_next;
    logic              frame_done_reg, frame_done_next;
    logic [15:0]       win_start, win_end;
    logic              x_wrap, y_wrap;

    assign win_start = pbuf_reg[23:8];
    assign win_end   = {pbuf_reg[7:0], rx_byte};
    // All-ones also wraps, which handles windows with start > end.
    assign x_wrap    = (x_reg == xe_reg) || (&x_reg);
    assign y_wrap    = (y_reg == ye_reg) || (&y_reg);

    always_comb begin
        state_next      = state_reg;
        pidx_next       = pidx_reg;
        pbuf_next       = pbuf_reg;
        hi_next         = hi_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        xs_next         = xs_reg;
        xe_next         = xe_reg;
        ys_next         = ys_reg;
        ye_next         = ye_reg;
        cmd_valid_next  = 1'b0;
        cmd_byte_next   = cmd_byte_reg;
        pix_valid_next  = 1'b0;
        pix_x_next      = pix_x_reg;
        pix_y_next      = pix_y_reg;
        pix_data_next   = pix_data_reg;
        frame_done_next = 1'b0;

        if (byte_done) begin
            if (!rx_rs) begin
                cmd_valid_next = 1'b1;
                cmd_byte_next  = rx_byte;
                pidx_next      = 2'd0;
                case (rx_byte)
                    8'h2A:   state_next = CASET_P;
                    8'h2B:   state_next = RASET_P;
                    8'h2C: begin
                        state_next = RAMWR_HI;
                        x_next     = xs_reg;
                        y_next     = ys_reg;
                    end
                    default: state_next = IDLE;
                endcase
            end else begin
                case (state_reg)
                    CASET_P, RASET_P: begin
                        if (pidx_reg == 2'd3) begin
                            if (state_reg == CASET_P) begin
                                xs_next = win_start[ADDR_W-1:0];
                                xe_next = win_end[ADDR_W-1:0];
                            end else begin
                                ys_next = win_start[ADDR_W-1:0];
                                ye_next = win_end[ADDR_W-1:0];
                            end
                            pidx_next  = 2'd0;
                            state_next = IDLE;
                        end else begin
                            pbuf_next = {pbuf_reg[15:0], rx_byte};
                            pidx_next = pidx_reg + 2'd1;
                        end
                    end
                    RAMWR_HI: begin
                        hi_next    = rx_byte;
                        state_next = RAMWR_LO;
                    end
                    RAMWR_LO: begin
                        pix_valid_next  = 1'b1;
                        pix_x_next      = x_reg;
                        pix_y_next      = y_reg;
                        pix_data_next   = {hi_reg, rx_byte};
                        frame_done_next = (x_reg == xe_reg) && (y_reg == ye_reg);
                        if (x_wrap) begin
                            x_next = xs_reg;
                            y_next = y_wrap ? ys_reg : y_reg + ONE_W;
                        end else begin
                            x_next = x_reg + ONE_W;
                        end
                        state_next = RAMWR_HI;
                    end
                    default: ;   // data bytes outside a command are dropped
                endcase
            end
        end

        if (soft_rst) begin
            state_next      = IDLE;
            pidx_next       = 2'd0;
            pbuf_next       = '0;
            hi_next         = '0;
            x_next          = '0;
            y_next          = '0;
            xs_next         = '0;
            xe_next         = DEF_XE_W;
            ys_next         = '0;
            ye_next         = DEF_YE_W;
            cmd_valid_next  = 1'b0;
            cmd_byte_next   = '0;
            pix_valid_next  = 1'b0;
            pix_x_next      = '0;
            pix_y_next      = '0;
            pix_data_next   = '0;
            frame_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pidx_reg       <= 2'd0;
            pbuf_reg       <= '0;
            hi_reg         <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            xs_reg         <= '0;
            xe_reg         <= DEF_XE_W;
            ys_reg         <= '0;
            ye_reg         <= DEF_YE_W;
            cmd_valid_reg  <= 1'b0;
            cmd_byte_reg   <= '0;
            pix_valid_reg  <= 1'b0;
            pix_x_reg      <= '0;
            pix_y_reg      <= '0;
            pix_data_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pidx_reg       <= pidx_next;
            pbuf_reg       <= pbuf_next;
            hi_reg         <= hi_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            xs_reg         <= xs_next;
            xe_reg         <= xe_next;
            ys_reg         <= ys_next;
            ye_reg         <= ye_next;
            cmd_valid_reg  <= cmd_valid_next;
            cmd_byte_reg   <= cmd_byte_next;
            pix_valid_reg  <= pix_valid_next;
            pix_x_reg      <= pix_x_next;
            pix_y_reg      <= pix_y_next;
            pix_data_reg   <= pix_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

`ifdef LCD_SPI_RX_BYTECNT_EN
    logic [15:0] byte_cnt_reg, cmd_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= '0;
            cmd_cnt_reg  <= '0;
        end else if (soft_rst) begin
            byte_cnt_reg <= '0;
            cmd_cnt_reg  <= '0;
        end else if (byte_done) begin
            if (byte_cnt_reg != 16'hFFFF) byte_cnt_reg <= byte_cnt_reg + 16'd1;
            if (!rx_rs && cmd_cnt_reg != 16'hFFFF) cmd_cnt_reg <= cmd_cnt_reg + 16'd1;
        end
    end

    assign byte_cnt = byte_cnt_reg;
    assign cmd_cnt  = cmd_cnt_reg;
`endif

    assign cmd_valid  = cmd_valid_reg;
    assign cmd_byte   = cmd_byte_reg;
    assign pix_valid  = pix_valid_reg;
    assign pix_x      = pix_x_reg;
    assign pix_y      = pix_y_reg;
    assign pix_data   = pix_data_reg;
    assign frame_done = frame_done_reg;
    assign frag_err   = frag_err_reg;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_rx : directed self-checking bench for lcd_spi_rx.
// A negedge monitor logs every strobe into queues; the linear stimulus below
// drives SPI bytes and compares the logs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_spi_rx;

    localparam int HALF = 4;   // scl half period in clk cycles (>= SYNC_STAGES+1)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_lcd = 1'b0, sda_lcd = 1'b0, cs_lcd = 1'b1, rs_lcd = 1'b0;
    logic        rst_lcd = 1'b1;
    logic        cmd_valid, pix_valid, frame_done, frag_err;
    logic [7:0]  cmd_byte, pix_x, pix_y;
    logic [15:0] pix_data;
`ifdef LCD_SPI_RX_BYTECNT_EN
    logic [15:0] byte_cnt, cmd_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lcd_spi_rx dut (
        .clk        (clk),
        .rst        (rst),
        .scl_lcd    (scl_lcd),
        .sda_lcd    (sda_lcd),
        .cs_lcd     (cs_lcd),
        .rs_lcd     (rs_lcd),
        .rst_lcd    (rst_lcd),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .frame_done (frame_done),
`ifdef LCD_SPI_RX_BYTECNT_EN
        .byte_cnt   (byte_cnt),
        .cmd_cnt    (cmd_cnt),
`endif
        .frag_err   (frag_err)
    );

    always #5 clk = ~clk;

    // ---- strobe monitor: pixel entry = {frame_done, x, y, data} ----
    logic [7:0]  cmd_q[$];
    logic [32:0] pix_q[$];
    int          fd_cnt = 0;
    int          frag_cnt = 0;

    always @(negedge clk) begin
        if (cmd_valid)  cmd_q.push_back(cmd_byte);
        if (pix_valid)  pix_q.push_back({frame_done, pix_x, pix_y, pix_data});
        if (frame_done) fd_cnt++;
        if (frag_err)   frag_cnt++;
    end

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_lcd = b;
        scl_lcd = 1'b0;
        wait_clk(HALF);
        scl_lcd = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs);
        if (cs_lcd) begin
            cs_lcd = 1'b0;
            wait_clk(HALF);
        end
        rs_lcd = rs;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        scl_lcd = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic settle();
        scl_lcd = 1'b0;
        cs_lcd  = 1'b1;
        wait_clk(20);
    endtask

    task automatic clear_logs();
        cmd_q.delete();
        pix_q.delete();
        fd_cnt   = 0;
        frag_cnt = 0;
    endtask

    function automatic logic [32:0] pix(input logic fd, input logic [7:0] x,
                                        input logic [7:0] y, input logic [15:0] d);
        return {fd, x, y, d};
    endfunction

    initial begin
        // ---- reset and idle lines ----
        wait_clk(3);
        rst = 1'b0;
        wait_clk(20);
        check("rst_strobes", {29'd0, cmd_valid, pix_valid, frame_done, frag_err}, 33'd0);
        check("rst_cmd_byte", {25'd0, cmd_byte}, 33'd0);
        check("rst_pix", {1'b0, pix_x, pix_y, pix_data}, 33'd0);
        check("idle_no_evts", 33'(cmd_q.size() + pix_q.size() + frag_cnt), 33'd0);

        // ---- CASET 5..7, RASET 2..3, RAMWR 6 pixels + 1 wrap ----
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1);
        send_byte(8'h2B, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hAA, 1'b1);
            send_byte(8'hBB, 1'b1);
        end
        settle();
        check("win_cmd_cnt", 33'(cmd_q.size()), 33'd3);
        if (cmd_q.size() == 3) begin
            check("win_cmd0", {25'd0, cmd_q[0]}, 33'h2A);
            check("win_cmd1", {25'd0, cmd_q[1]}, 33'h2B);
            check("win_cmd2", {25'd0, cmd_q[2]}, 33'h2C);
        end
        check("win_pix_cnt", 33'(pix_q.size()), 33'd6);
        if (pix_q.size() == 6) begin
            check("win_pix0", pix_q[0], pix(1'b0, 8'd5, 8'd2, 16'hAABB));
            check("win_pix1", pix_q[1], pix(1'b0, 8'd6, 8'd2, 16'hAABB));
            check("win_pix2", pix_q[2], pix(1'b0, 8'd7, 8'd2, 16'hAABB));
            check("win_pix3", pix_q[3], pix(1'b0, 8'd5, 8'd3, 16'hAABB));
            check("win_pix4", pix_q[4], pix(1'b0, 8'd6, 8'd3, 16'hAABB));
            check("win_pix5", pix_q[5], pix(1'b1, 8'd7, 8'd3, 16'hAABB));
        end
        check("win_fd_cnt", 33'(fd_cnt), 33'd1);
        clear_logs();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        settle();
        check("wrap_pix_cnt", 33'(pix_q.size()), 33'd1);
        if (pix_q.size() == 1) check("wrap_pix", pix_q[0], pix(1'b0, 8'd5, 8'd2, 16'h1234));
        clear_logs();

        // ---- half pixel discarded by a new command ----
        send_byte(8'h2C, 1'b0);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b1);   // in IDLE these must be ignored
        send_byte(8'h22, 1'b1);
        settle();
        check("half_cmd_cnt", 33'(cmd_q.size()), 33'd2);
        check("half_pix_cnt", 33'(pix_q.size()), 33'd0);
        check("half_cmd_byte", {25'd0, cmd_byte}, 33'h01);
        clear_logs();

        // ---- fragment: 5 bits then cs high ----
        cs_lcd = 1'b0;
        wait_clk(HALF);
        rs_lcd = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        settle();
        check("frag_pulses", 33'(frag_cnt), 33'd1);
        check("frag_no_cmd", 33'(cmd_q.size()), 33'd0);
        send_byte(8'h2C, 1'b0);
        settle();
        check("post_frag_cmd", 33'(cmd_q.size()), 33'd1);
        if (cmd_q.size() == 1) check("post_frag_val", {25'd0, cmd_q[0]}, 33'h2C);
        clear_logs();

        // ---- async reset mid-RAMWR (after half pixel, mid-byte) ----
        send_byte(8'hAA, 1'b1);   // produces first pixel at (5,2)
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);   // half pixel pending
        rs_lcd = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("pre_rst_x", {25'd0, pix_x}, 33'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cmd_byte", {25'd0, cmd_byte}, 33'd0);
        check("arst_pix", {1'b0, pix_x, pix_y, pix_data}, 33'd0);
        check("arst_strobes", {29'd0, cmd_valid, pix_valid, frame_done, frag_err}, 33'd0);
        scl_lcd = 1'b0;
        cs_lcd  = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        clear_logs();

        // ---- default window: 129 pixels, x wraps at 127 ----
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 129; i++) begin
            send_byte(8'(i), 1'b1);
            send_byte(8'h3C, 1'b1);
        end
        settle();
        check("def_cmd", 33'(cmd_q.size()), 33'd1);
        check("def_pix_cnt", 33'(pix_q.size()), 33'd129);
        if (pix_q.size() == 129) begin
            check("def_pix0", pix_q[0], pix(1'b0, 8'd0, 8'd0, 16'h003C));
            check("def_pix127", pix_q[127], pix(1'b0, 8'd127, 8'd0, 16'h7F3C));
            check("def_pix128", pix_q[128], pix(1'b0, 8'd0, 8'd1, 16'h803C));
        end
        check("def_fd_cnt", 33'(fd_cnt), 33'd0);
        clear_logs();

        // ---- data in IDLE, truncated CASET, then RAMWR ----
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h09, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h2C, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        settle();
        check("trunc_cmd_cnt", 33'(cmd_q.size()), 33'd3);
        check("trunc_pix_cnt", 33'(pix_q.size()), 33'd1);
        if (pix_q.size() == 1) check("trunc_pix", pix_q[0], pix(1'b0, 8'd0, 8'd0, 16'h1234));
        clear_logs();

        // ---- panel soft reset via rst_lcd ----
        rst_lcd = 1'b0;
        wait_clk(6);
        check("soft_cmd_byte", {25'd0, cmd_byte}, 33'd0);
        check("soft_pix_data", {17'd0, pix_data}, 33'd0);
        rst_lcd = 1'b1;
        wait_clk(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #5ms;
        $display("FAIL timeout: observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule
